// File: rtl/fwd_bypass_network.sv
// Operand-forwarding unit for the integer pipeline.
// Tracks DEPTH in-flight destination tags (stage 0 = EX, stage 1 = MEM, ...),
// resolves two source operands to the youngest matching in-flight result or the
// register-file value, stalls on a load-use hazard at stage 0 and issues
// registered operands to EX.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   flush_i               kill all in-flight tags and the pending operand issue
//   issue_valid_i         decode presents an instruction this cycle
//   rs_a_i, rs_b_i        source registers; rf_a_i, rf_b_i register-file data
//   wb_en_i, rd_i         issuing instruction writes rd_i
//   is_load_i             issuing instruction is a load
//   stage_data_i          result held in tag stage k at [k*DATA_W +: DATA_W]
//   stall_o               combinational hold request towards decode
//   op_valid_o            registered operands valid for EX
//   op_a_o, op_b_o        registered forwarded operands
//   sel_a_o, sel_b_o      registered source: 0 = register file, k+1 = stage k
//   fwd_count_o           saturating count of forwarded operands
//   stall_count_o         saturating count of stall cycles
module fwd_bypass_network #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned SelW  = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    issue_valid_i,
    input  logic [REG_AW-1:0]       rs_a_i,
    input  logic [REG_AW-1:0]       rs_b_i,
    input  logic [DATA_W-1:0]       rf_a_i,
    input  logic [DATA_W-1:0]       rf_b_i,
    input  logic                    wb_en_i,
    input  logic [REG_AW-1:0]       rd_i,
    input  logic                    is_load_i,
    input  logic [DEPTH*DATA_W-1:0] stage_data_i,
    output logic                    stall_o,
    output logic                    op_valid_o,
    output logic [DATA_W-1:0]       op_a_o,
    output logic [DATA_W-1:0]       op_b_o,
    output logic [SelW-1:0]         sel_a_o,
    output logic [SelW-1:0]         sel_b_o,
    output logic [CNT_W-1:0]        fwd_count_o,
    output logic [CNT_W-1:0]        stall_count_o
);

    logic              valid_q [DEPTH];
    logic [REG_AW-1:0] rd_q    [DEPTH];
    logic              load_q  [DEPTH];

    logic [DEPTH-1:0]  hit_a, hit_b;
    logic [SelW-1:0]   sel_a_d, sel_b_d;
    logic [DATA_W-1:0] op_a_d, op_b_d;
    logic              fire;
    logic [1:0]        fwd_inc;
    logic [CNT_W:0]    fwd_sum;
    logic [CNT_W-1:0]  fwd_count_d, stall_count_d;

    // Operand resolution: scan oldest to youngest so the lowest k wins.
    always_comb begin
        hit_a   = '0;
        hit_b   = '0;
        sel_a_d = '0;
        sel_b_d = '0;
        op_a_d  = rf_a_i;
        op_b_d  = rf_b_i;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            hit_a[k] = valid_q[k] && (rd_q[k] == rs_a_i) && (rs_a_i != '0);
            hit_b[k] = valid_q[k] && (rd_q[k] == rs_b_i) && (rs_b_i != '0);
            if (hit_a[k]) begin
                sel_a_d = SelW'(k + 1);
                op_a_d  = stage_data_i[k*DATA_W +: DATA_W];
            end
            if (hit_b[k]) begin
                sel_b_d = SelW'(k + 1);
                op_b_d  = stage_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // A hit at stage 0 always wins, so a stage-0 load hit is a load-use hazard.
    assign stall_o = issue_valid_i && !flush_i && load_q[0] && (hit_a[0] || hit_b[0]);
    assign fire    = issue_valid_i && !stall_o && !flush_i;

    always_comb begin
        fwd_inc     = {1'b0, sel_a_d != '0} + {1'b0, sel_b_d != '0};
        fwd_sum     = {1'b0, fwd_count_o} + {{(CNT_W - 1){1'b0}}, fwd_inc};
        fwd_count_d = fwd_count_o;
        if (fire) begin
            fwd_count_d = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
        end
        stall_count_d = stall_count_o;
        if (stall_o && (stall_count_o != '1)) begin
            stall_count_d = stall_count_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                rd_q[k]    <= '0;
                load_q[k]  <= 1'b0;
            end
            op_valid_o    <= 1'b0;
            op_a_o        <= '0;
            op_b_o        <= '0;
            sel_a_o       <= '0;
            sel_b_o       <= '0;
            fwd_count_o   <= '0;
            stall_count_o <= '0;
        end else if (flush_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_q[k] <= 1'b0;
            end
            op_valid_o <= 1'b0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                valid_q[k] <= valid_q[k-1];
                rd_q[k]    <= rd_q[k-1];
                load_q[k]  <= load_q[k-1];
            end
            // Stalls and non-writing instructions insert a bubble; r0 is never tracked.
            valid_q[0] <= fire && wb_en_i && (rd_i != '0);
            rd_q[0]    <= rd_i;
            load_q[0]  <= is_load_i;
            op_valid_o <= fire;
            if (fire) begin
                op_a_o  <= op_a_d;
                op_b_o  <= op_b_d;
                sel_a_o <= sel_a_d;
                sel_b_o <= sel_b_d;
            end
            fwd_count_o   <= fwd_count_d;
            stall_count_o <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_fwd_bypass_network.sv
module tb_fwd_bypass_network;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SelW   = $clog2(DEPTH + 1);

    logic                    clk, rst, flush, issue_valid, wb_en, is_load;
    logic [REG_AW-1:0]       rs_a, rs_b, rd;
    logic [DATA_W-1:0]       rf_a, rf_b;
    logic [DEPTH*DATA_W-1:0] stage_data;
    logic                    stall, op_valid;
    logic [DATA_W-1:0]       op_a, op_b;
    logic [SelW-1:0]         sel_a, sel_b;
    logic [CNT_W-1:0]        fwd_count, stall_count;

    int total = 0;
    int bad   = 0;

    fwd_bypass_network #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .issue_valid_i (issue_valid),
        .rs_a_i        (rs_a),
        .rs_b_i        (rs_b),
        .rf_a_i        (rf_a),
        .rf_b_i        (rf_b),
        .wb_en_i       (wb_en),
        .rd_i          (rd),
        .is_load_i     (is_load),
        .stage_data_i  (stage_data),
        .stall_o       (stall),
        .op_valid_o    (op_valid),
        .op_a_o        (op_a),
        .op_b_o        (op_b),
        .sel_a_o       (sel_a),
        .sel_b_o       (sel_b),
        .fwd_count_o   (fwd_count),
        .stall_count_o (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush       = 1'b0;
        issue_valid = 1'b0;
        wb_en       = 1'b0;
        is_load     = 1'b0;
        rs_a        = '0;
        rs_b        = '0;
        rd          = '0;
        rf_a        = '0;
        rf_b        = '0;
        stage_data  = '0;
    endtask

    task automatic issue(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b,
                         input logic w, input logic [REG_AW-1:0] d, input logic ld);
        issue_valid = 1'b1;
        rs_a        = a;
        rs_b        = b;
        wb_en       = w;
        rd          = d;
        is_load     = ld;
    endtask

    task automatic test_reset();
        issue(0, 0, 1, 5, 0);
        step();
        issue(5, 0, 0, 0, 0);
        stage_data = {32'h0, 32'hCAFE};
        step();
        total++;
        if (op_a !== 32'hCAFE || sel_a !== 2'd1 || fwd_count !== 16'd1) begin
            bad++;
            $display("FAIL pre_reset_fwd: op_a=%h sel_a=%0d fwd=%0d want cafe/1/1",
                     op_a, sel_a, fwd_count);
        end
        // Async reset mid-cycle with a valid tag and a live issue.
        issue(5, 5, 1, 5, 0);
        rst = 1'b1;
        #1;
        total++;
        if (op_valid !== 1'b0 || op_a !== '0 || op_b !== '0 || sel_a !== '0 || sel_b !== '0) begin
            bad++;
            $display("FAIL reset_ops: v=%b a=%h b=%h sa=%0d sb=%0d want all 0",
                     op_valid, op_a, op_b, sel_a, sel_b);
        end
        total++;
        if (fwd_count !== '0 || stall_count !== '0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_cnt: fwd=%0d stc=%0d stall=%b want 0/0/0",
                     fwd_count, stall_count, stall);
        end
        step();
        rst = 1'b0;
        idle();
        issue(5, 0, 0, 0, 0);
        rf_a       = 32'h77;
        stage_data = {32'hBAD1, 32'hBAD0};
        step();
        total++;
        if (op_a !== 32'h77 || sel_a !== 2'd0 || op_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_after: op_a=%h sel_a=%0d v=%b want 77/0/1", op_a, sel_a, op_valid);
        end
        idle();
    endtask

    task automatic test_ex_forward();
        issue(0, 0, 1, 5, 0);
        step();
        issue(5, 0, 0, 0, 0);
        rf_a       = 32'hDEAD;
        stage_data = {32'h0, 32'h1234};
        step();
        total++;
        if (op_a !== 32'h1234 || sel_a !== 2'd1 || op_valid !== 1'b1 || fwd_count !== 16'd1) begin
            bad++;
            $display("FAIL ex_forward: op_a=%h sel_a=%0d v=%b fwd=%0d want 1234/1/1/1",
                     op_a, sel_a, op_valid, fwd_count);
        end
        idle();
    endtask

    task automatic test_priority();
        issue(0, 0, 1, 3, 0);
        step();
        step();
        issue(0, 3, 0, 0, 0);
        rf_b       = 32'hEEEE;
        stage_data = {32'hA, 32'hB};
        step();
        total++;
        if (op_b !== 32'hB || sel_b !== 2'd1 || fwd_count !== 16'd2) begin
            bad++;
            $display("FAIL priority: op_b=%h sel_b=%0d fwd=%0d want b/1/2", op_b, sel_b, fwd_count);
        end
        idle();
    endtask

    task automatic test_load_use();
        issue(0, 0, 1, 7, 1);
        step();
        issue(7, 0, 0, 0, 0);
        rf_a = 32'h1111;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL load_stall: stall=%b want 1", stall);
        end
        step();
        total++;
        if (op_valid !== 1'b0 || stall_count !== 16'd1) begin
            bad++;
            $display("FAIL load_bubble: v=%b stc=%0d want 0/1", op_valid, stall_count);
        end
        stage_data = {32'h55, 32'h0};
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL load_release: stall=%b want 0", stall);
        end
        step();
        total++;
        if (op_a !== 32'h55 || sel_a !== 2'd2 || op_valid !== 1'b1 || stall_count !== 16'd1) begin
            bad++;
            $display("FAIL load_mem_fwd: op_a=%h sel_a=%0d v=%b stc=%0d want 55/2/1/1",
                     op_a, sel_a, op_valid, stall_count);
        end
        idle();
    endtask

    task automatic test_r0_flush();
        issue(0, 0, 1, 0, 0);
        step();
        issue(0, 0, 0, 0, 0);
        rf_a       = 32'h9;
        stage_data = {32'hBAD1, 32'hBAD0};
        step();
        total++;
        if (op_a !== 32'h9 || sel_a !== 2'd0) begin
            bad++;
            $display("FAIL r0: op_a=%h sel_a=%0d want 9/0", op_a, sel_a);
        end
        idle();
        issue(0, 0, 1, 4, 0);
        step();
        issue(4, 0, 0, 0, 0);
        flush = 1'b1;
        step();
        total++;
        if (op_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_kill: v=%b want 0", op_valid);
        end
        flush      = 1'b0;
        rf_a       = 32'h44;
        stage_data = {32'hF1, 32'hF0};
        step();
        total++;
        if (op_a !== 32'h44 || sel_a !== 2'd0 || op_valid !== 1'b1) begin
            bad++;
            $display("FAIL flush_nofwd: op_a=%h sel_a=%0d v=%b want 44/0/1", op_a, sel_a, op_valid);
        end
        idle();
    endtask

    task automatic test_same_reg();
        issue(0, 0, 1, 6, 0);
        step();
        issue(6, 6, 0, 0, 0);
        rf_a       = 32'h1;
        rf_b       = 32'h2;
        stage_data = {32'h0, 32'h66};
        step();
        total++;
        if (op_a !== 32'h66 || op_b !== 32'h66 || sel_a !== 2'd1 || sel_b !== 2'd1) begin
            bad++;
            $display("FAIL same_reg: a=%h b=%h sa=%0d sb=%0d want 66/66/1/1",
                     op_a, op_b, sel_a, sel_b);
        end
        idle();
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        step();
        rst = 1'b0;
        issue(1, 1, 1, 1, 0);
        stage_data = {32'h0, 32'h5A};
        // First issue has no hit; each later one forwards both operands (+2).
        for (int i = 0; i < 32768; i++) step();
        total++;
        if (fwd_count !== 16'hFFFE) begin
            bad++;
            $display("FAIL sat_preload: fwd=%h want fffe", fwd_count);
        end
        step();
        total++;
        if (fwd_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_max: fwd=%h want ffff", fwd_count);
        end
        step();
        total++;
        if (fwd_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_hold: fwd=%h want ffff", fwd_count);
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_ex_forward();
        test_priority();
        test_load_use();
        test_r0_flush();
        test_same_reg();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
